threshold_detector: RTL

Parametrised, registered generalisation of the three-input pair/triple detector. The block counts how many of NBITS input bits are high on each valid sample, compares that count against a threshold, and asserts `out` only after the threshold has been met on HOLD consecutive valid samples. It is the voting/debounce stage used ahead of control logic that must ignore single-sample glitches.

---
 rtl/threshold_detector.sv | 114 +++++++++++
 1 files changed

// File: rtl/threshold_detector.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | threshold_detector                                                       |
// | Counts ones across NBITS inputs and asserts `out` after HOLD consecutive |
// | valid samples reach THRESH. Optional sticky alarm is built only when     |
// | THRESHOLD_DETECTOR_STICKY_EN is defined.                                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module threshold_detector #(
  parameter int NBITS  = 3,
  parameter int THRESH = 2,
  parameter int HOLD   = 1,
  localparam int CW = ($clog2(NBITS + 1) < 1) ? 1 : $clog2(NBITS + 1),
  localparam int RW = ($clog2(HOLD + 1) < 1) ? 1 : $clog2(HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_val,
  input  logic [NBITS-1:0] in,
  input  logic          clr,
  output logic          out,
  output logic [CW-1:0] count,
  output logic          alarm
);

  // Illegal parameter combinations are reported at elaboration
  if (NBITS < 1) begin : g_chk_nbits
    $error("threshold_detector: NBITS must be >= 1");
  end
  if (THRESH < 1 || THRESH > NBITS) begin : g_chk_thresh
    $error("threshold_detector: THRESH must be in 1..NBITS");
  end
  if (HOLD < 1) begin : g_chk_hold
    $error("threshold_detector: HOLD must be >= 1");
  end

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMING = 2'd1;
  localparam logic [1:0] ST_DETECT = 2'd2;

  localparam logic [RW-1:0] RUN_HOLD   = RW'(HOLD);
  localparam logic [CW-1:0] THRESH_CNT = CW'(THRESH);

  logic [CW-1:0] pop;
  logic          hit;
  logic [RW-1:0] run;
  logic [RW-1:0] run_next;
  logic [1:0]    state;
  logic          out_next;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NBITS; i++) begin
      pop = pop + CW'(in[i]);
    end
  end

  assign hit = (pop >= THRESH_CNT);

  // Run-counter states are a decode of the counter, not separate flops
  always_comb begin
    if (run == '0) begin
      state = ST_IDLE;
    end else if (run == RUN_HOLD) begin
      state = ST_DETECT;
    end else begin
      state = ST_ARMING;
    end
  end

  always_comb begin
    run_next = run;
    case (state)
      ST_IDLE,
      ST_ARMING: run_next = hit ? (run + 1'b1) : '0;
      ST_DETECT: run_next = hit ? run : '0;
      default:   run_next = '0;
    endcase
  end

  assign out_next = in_val ? (run_next == RUN_HOLD) : out;

  always_ff @(posedge clk) begin
    if (rst) begin
      run   <= '0;
      count <= '0;
      out   <= 1'b0;
    end else if (in_val) begin
      run   <= run_next;
      count <= pop;
      out   <= out_next;
    end
  end

`ifdef THRESHOLD_DETECTOR_STICKY_EN
  // A set in the same cycle as clr takes precedence
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm <= 1'b0;
    end else if (out_next) begin
      alarm <= 1'b1;
    end else if (clr) begin
      alarm <= 1'b0;
    end
  end
`else
  logic clr_unused;
  assign clr_unused = clr;
  assign alarm      = 1'b0;
`endif

endmodule
`default_nettype wire
